// File: rtl/udcnt_pkg.sv
// rtl/udcnt_pkg.sv - shared constants, count-mode encoding and helpers for updown_mod_counter
package udcnt_pkg;

   // Default geometry of the counter and its prescaler
   localparam int UDCNT_WIDTH   = 8;
   localparam int UDCNT_PRESC_W = 4;

   // Encoding of the terminal-step flag produced by the step logic
   localparam logic TERMINAL     = 1'b1;
   localparam logic NON_TERMINAL = 1'b0;

   // Count mode is simply {up_dn, sat_mode}
   typedef enum logic [1:0] {
      DN_WRAP = 2'b00,
      DN_SAT  = 2'b01,
      UP_WRAP = 2'b10,
      UP_SAT  = 2'b11
   } count_mode_e;

   function automatic count_mode_e mode_of(input logic up_dn, input logic sat_mode);
      return count_mode_e'({up_dn, sat_mode});
   endfunction

endpackage

// File: rtl/udcnt_prescaler.sv
// rtl/udcnt_prescaler.sv - clock-enable divider producing one tick every presc_div+1 enabled cycles
module udcnt_prescaler
   import udcnt_pkg::*;
#(
   parameter int PRESC_W = UDCNT_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               restart,
   input  logic [PRESC_W-1:0] presc_div,
   output logic               tick
);

   logic [PRESC_W-1:0] presc_cnt;

   // Tick fires on the enabled cycle where the divider reaches its programmed terminal
   assign tick = ena && (presc_cnt == presc_div);

   // Divider state: restart wins, frozen while ena is low, wraps to zero on tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else if (restart) begin
         presc_cnt <= '0;
      end else if (ena) begin
         if (tick) presc_cnt <= '0;
         else      presc_cnt <= presc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - loadable up/down modulo counter with prescaler, tc pulse and sticky ovf; UDCNT_CAPTURE_EN adds capture/cap_val
module updown_mod_counter
   import udcnt_pkg::*;
#(
   parameter int WIDTH   = UDCNT_WIDTH,
   parameter int PRESC_W = UDCNT_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               clear,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               up_dn,
   input  logic               sat_mode,
   input  logic [WIDTH-1:0]   max_val,
   input  logic [PRESC_W-1:0] presc_div,
`ifdef UDCNT_CAPTURE_EN
   input  logic               capture,
   output logic [WIDTH-1:0]   cap_val,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               ovf
);

   logic              tick;
   logic              term;
   logic [WIDTH-1:0]  next_count;
   logic [WIDTH-1:0]  load_clamped;
   count_mode_e       mode;

   udcnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .restart   (clear | load),
      .presc_div (presc_div),
      .tick      (tick)
   );

   // Step result and terminal detection; a count above max_val is terminal only when counting up
   always_comb begin
      mode         = mode_of(up_dn, sat_mode);
      next_count   = count;
      term         = NON_TERMINAL;
      load_clamped = (load_val > max_val) ? max_val : load_val;
      case (mode)
         UP_WRAP, UP_SAT: begin
            if (count >= max_val) begin
               term       = TERMINAL;
               next_count = (mode == UP_SAT) ? max_val : '0;
            end else begin
               next_count = count + 1'b1;
            end
         end
         default: begin
            if (count == '0) begin
               term       = TERMINAL;
               next_count = (mode == DN_SAT) ? '0 : max_val;
            end else begin
               next_count = count - 1'b1;
            end
         end
      endcase
   end

   // Count, tc and ovf registers: clear > load > step, tc only lives for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else if (clear) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else if (tick) begin
         count <= next_count;
         tc    <= term;
         ovf   <= ovf | term;
      end else begin
         tc    <= 1'b0;
      end
   end

`ifdef UDCNT_CAPTURE_EN
   // Snapshot of the pre-update count, independent of ena/clear/load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cap_val <= '0;
      else if (capture) cap_val <= count;
   end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ena;
   logic               clear;
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic               up_dn;
   logic               sat_mode;
   logic [WIDTH-1:0]   max_val;
   logic [PRESC_W-1:0] presc_div;
   logic [WIDTH-1:0]   count;
   logic               tc;
   logic               ovf;
`ifdef UDCNT_CAPTURE_EN
   logic               capture;
   logic [WIDTH-1:0]   cap_val;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   updown_mod_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .up_dn     (up_dn),
      .sat_mode  (sat_mode),
      .max_val   (max_val),
      .presc_div (presc_div),
`ifdef UDCNT_CAPTURE_EN
      .capture   (capture),
      .cap_val   (cap_val),
`endif
      .count     (count),
      .tc        (tc),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance one clock edge and settle 1 ns after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
      up_dn = 1'b1; sat_mode = 1'b0; max_val = 8'd9; presc_div = '0;
`ifdef UDCNT_CAPTURE_EN
      capture = 1'b0;
`endif
      // Reset held while enabled
      repeat (3) cyc();
      check("rst_count", 32'(count), 0);
      check("rst_tc",    32'(tc),    0);
      check("rst_ovf",   32'(ovf),   0);
      rst_n = 1'b1;
      cyc();
      check("rst_first_tick", 32'(count), 1);

      // Up wrap 0..9,0,1
      clear = 1'b1; cyc(); clear = 1'b0;
      check("clr_count", 32'(count), 0);
      for (int i = 1; i <= 11; i++) begin
         cyc();
         check($sformatf("upw_count%0d", i), 32'(count), 32'(i % 10));
         check($sformatf("upw_tc%0d", i),    32'(tc),    32'(i == 10));
         check($sformatf("upw_ovf%0d", i),   32'(ovf),   32'(i >= 10));
      end

      // Asynchronous reset mid-operation
      rst_n = 1'b0;
      #2;
      check("arst_count", 32'(count), 0);
      check("arst_ovf",   32'(ovf),   0);
      check("arst_tc",    32'(tc),    0);
      cyc();
      rst_n = 1'b1;

      // Down saturate from 2
      up_dn = 1'b0; sat_mode = 1'b1; load = 1'b1; load_val = 8'd2;
      cyc(); load = 1'b0;
      check("dns_load", 32'(count), 2);
      begin
         int exp_c[4]   = '{1, 0, 0, 0};
         int exp_tc[4]  = '{0, 0, 1, 1};
         int exp_ovf[4] = '{0, 0, 1, 1};
         for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("dns_count%0d", i), 32'(count), 32'(exp_c[i]));
            check($sformatf("dns_tc%0d", i),    32'(tc),    32'(exp_tc[i]));
            check($sformatf("dns_ovf%0d", i),   32'(ovf),   32'(exp_ovf[i]));
         end
      end

      // Load with a tick in the same cycle, ovf cleared
      load = 1'b1; load_val = 8'd5; cyc();
      check("ld_count", 32'(count), 5);
      check("ld_ovf",   32'(ovf),   0);
      // clear beats load
      clear = 1'b1; cyc(); clear = 1'b0;
      check("clr_over_ld", 32'(count), 0);
      // load clamps to max_val
      max_val = 8'd99; load_val = 8'd200; cyc(); load = 1'b0;
      check("ld_clamp", 32'(count), 99);

      // max_val lowered below count while counting up: terminal wrap
      max_val = 8'd9; up_dn = 1'b1; sat_mode = 1'b0; cyc();
      check("lowmax_count", 32'(count), 0);
      check("lowmax_tc",    32'(tc),    1);
      // Down wrap from 0 goes to max_val
      up_dn = 1'b0; cyc();
      check("dnw_count", 32'(count), 9);
      check("dnw_tc",    32'(tc),    1);
      cyc();
      check("dnw_next", 32'(count), 8);
      check("dnw_tc_low", 32'(tc), 0);

      // Prescaler: step every 4th enabled cycle
      up_dn = 1'b1; clear = 1'b1; cyc(); clear = 1'b0;
      presc_div = 4'd3;
      for (int i = 1; i <= 9; i++) begin
         cyc();
         check($sformatf("presc%0d", i), 32'(count), 32'(i / 4));
      end
      // ena low for 2 cycles mid-period stretches the period by 2
      ena = 1'b0;
      cyc(); check("presc_hold0", 32'(count), 2);
      cyc(); check("presc_hold1", 32'(count), 2);
      ena = 1'b1;
      cyc(); check("presc_a", 32'(count), 2);
      cyc(); check("presc_b", 32'(count), 2);
      cyc(); check("presc_c", 32'(count), 3);

`ifdef UDCNT_CAPTURE_EN
      presc_div = '0; load = 1'b1; load_val = 8'd6; cyc(); load = 1'b0;
      cyc();
      check("cap_pre", 32'(count), 7);
      capture = 1'b1; cyc(); capture = 1'b0;
      check("cap_val", 32'(cap_val), 7);
      check("cap_count", 32'(count), 8);
      cyc();
      check("cap_hold", 32'(cap_val), 7);
      check("cap_count2", 32'(count), 9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
